// File: rtl/game_pkg.sv
// game_pkg
// Shared constants for the maze game datapath: direction encodings coming
// from the button decoder, wall bit positions in a level-ROM word, spawn
// point and maze geometry, the movement FSM state codes, and two helpers.
// Ports: none (package).
package game_pkg;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0100;
  localparam logic [3:0] DIR_DOWN  = 4'b1000;

  localparam int WALL_TOP   = 3;
  localparam int WALL_BOT   = 2;
  localparam int WALL_LEFT  = 1;
  localparam int WALL_RIGHT = 0;

  localparam int START_X   = 394;
  localparam int START_Y   = 141;
  localparam int INFOBAR_H = 100;
  localparam int BLK       = 10;

  localparam logic [4:0] QUOT_MAX = 5'd31;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DIV      = 3'd1;
  localparam logic [2:0] ST_LOOK_CUR = 3'd2;
  localparam logic [2:0] ST_LOOK_ADJ = 3'd3;
  localparam logic [2:0] ST_DECIDE   = 3'd4;

  function automatic logic dir_one_hot(input logic [3:0] d);
    return (d == DIR_UP) || (d == DIR_LEFT) || (d == DIR_RIGHT) || (d == DIR_DOWN);
  endfunction

  // Subtraction that floors at zero instead of wrapping
  function automatic logic [10:0] sat_sub(input logic [10:0] a, input logic [10:0] b);
    return (a > b) ? (a - b) : 11'd0;
  endfunction

endpackage

// File: rtl/tile_divider.sv
// tile_divider
// Dual-channel sequential divider by repeated subtraction. One subtraction
// per channel per cycle; quotients saturate at 31. done is a one-cycle
// combinational pulse in the cycle where neither channel can subtract, and
// the quotient/remainder registers hold their values until the next start.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start                    load dividends and begin dividing
//   abort                    stop immediately (takes priority over start)
//   x_dividend, y_dividend   11-bit dividends
//   x_divisor, y_divisor     10-bit divisors (caller must not start with 0)
//   x_quot, y_quot           5-bit quotients
//   x_rem, y_rem             11-bit remainders
//   done                     division finished this cycle
module tile_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [10:0] x_dividend,
  input  logic [10:0] y_dividend,
  input  logic [9:0]  x_divisor,
  input  logic [9:0]  y_divisor,
  output logic [4:0]  x_quot,
  output logic [4:0]  y_quot,
  output logic [10:0] x_rem,
  output logic [10:0] y_rem,
  output logic        done
);
  import game_pkg::*;

  logic        run_q, run_d;
  logic [4:0]  x_quot_q, x_quot_d, y_quot_q, y_quot_d;
  logic [10:0] x_rem_q, x_rem_d, y_rem_q, y_rem_d;
  logic        x_step, y_step;

  assign x_step = run_q && (x_rem_q >= {1'b0, x_divisor}) && (x_quot_q != QUOT_MAX);
  assign y_step = run_q && (y_rem_q >= {1'b0, y_divisor}) && (y_quot_q != QUOT_MAX);
  assign done   = run_q && !x_step && !y_step;

  // Next-state: load on start, subtract while either channel still can
  always_comb begin
    run_d    = run_q;
    x_quot_d = x_quot_q;
    y_quot_d = y_quot_q;
    x_rem_d  = x_rem_q;
    y_rem_d  = y_rem_q;
    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      run_d    = 1'b1;
      x_rem_d  = x_dividend;
      y_rem_d  = y_dividend;
      x_quot_d = 5'd0;
      y_quot_d = 5'd0;
    end else if (run_q) begin
      if (x_step) begin
        x_rem_d  = x_rem_q - {1'b0, x_divisor};
        x_quot_d = x_quot_q + 5'd1;
      end
      if (y_step) begin
        y_rem_d  = y_rem_q - {1'b0, y_divisor};
        y_quot_d = y_quot_q + 5'd1;
      end
      if (done) run_d = 1'b0;
    end
  end

  // Divider state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      x_quot_q <= 5'd0;
      y_quot_q <= 5'd0;
      x_rem_q  <= 11'd0;
      y_rem_q  <= 11'd0;
    end else begin
      run_q    <= run_d;
      x_quot_q <= x_quot_d;
      y_quot_q <= y_quot_d;
      x_rem_q  <= x_rem_d;
      y_rem_q  <= y_rem_d;
    end
  end

  assign x_quot = x_quot_q;
  assign y_quot = y_quot_q;
  assign x_rem  = x_rem_q;
  assign y_rem  = y_rem_q;

endmodule

// File: rtl/player_move_ctrl.sv
// player_move_ctrl
// Sequences one player move per game tick: pixel position -> tile via
// tile_divider, wall lookup of the current tile then the adjacent tile over
// one shared level-ROM port, then commit or block a STEP-pixel move.
// Optional build macro WALL_ACK_TIMEOUT_EN: abort a move when wall_ack does
// not arrive within ACK_TIMEOUT cycles of a request (default: wait forever).
// Ports:
//   clk, rst                     clock, async active-high reset
//   tick, btn_dir                game tick pulse, one-hot direction
//   respawn, level_change        return to spawn / new level loaded
//   tile_w, tile_h, wall_margin  active level geometry
//   num_rows, num_cols           active level size
//   wall_req, wall_row, wall_col level-ROM lookup request and address
//   wall_ack, walls_in           lookup response {top,bottom,left,right}
//   pos_x, pos_y                 player top-left pixel
//   cur_row, cur_col             tile of last computed position
//   busy, move_done              FSM not idle / move committed pulse
module player_move_ctrl #(
  parameter int STEP      = 2,
  parameter int BLK       = game_pkg::BLK,
  parameter int INFOBAR_H = game_pkg::INFOBAR_H,
  parameter int START_X   = game_pkg::START_X,
  parameter int START_Y   = game_pkg::START_Y
`ifdef WALL_ACK_TIMEOUT_EN
  , parameter int ACK_TIMEOUT = 15
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [3:0]  btn_dir,
  input  logic        respawn,
  input  logic        level_change,
  input  logic [9:0]  tile_w,
  input  logic [9:0]  tile_h,
  input  logic [9:0]  wall_margin,
  input  logic [4:0]  num_rows,
  input  logic [4:0]  num_cols,
  output logic        wall_req,
  output logic [4:0]  wall_row,
  output logic [4:0]  wall_col,
  input  logic        wall_ack,
  input  logic [3:0]  walls_in,
  output logic [10:0] pos_x,
  output logic [10:0] pos_y,
  output logic [4:0]  cur_row,
  output logic [4:0]  cur_col,
  output logic        busy,
  output logic        move_done
);
  import game_pkg::*;

  logic [2:0]  state_q, state_d;
  logic [3:0]  dir_q, dir_d;
  logic [10:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [4:0]  cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  logic [3:0]  walls_cur_q, walls_cur_d, walls_adj_q, walls_adj_d;
  logic        wall_req_q, wall_req_d;
  logic [4:0]  wall_row_q, wall_row_d, wall_col_q, wall_col_d;
  logic        move_done_q, move_done_d;
`ifdef WALL_ACK_TIMEOUT_EN
  logic [3:0]  tmo_q, tmo_d;
`endif

  logic        div_start, div_abort, div_done;
  logic [4:0]  div_x_quot, div_y_quot;
  logic [10:0] div_x_rem, div_y_rem;
  logic [4:0]  adj_row, adj_col;
  logic        blocked;
  logic [10:0] margin_w;

  assign margin_w = {1'b0, wall_margin};

  tile_divider u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (div_start),
    .abort      (div_abort),
    .x_dividend (pos_x_q),
    .y_dividend (pos_y_q - 11'(INFOBAR_H)),
    .x_divisor  (tile_w),
    .y_divisor  (tile_h),
    .x_quot     (div_x_quot),
    .y_quot     (div_y_quot),
    .x_rem      (div_x_rem),
    .y_rem      (div_y_rem),
    .done       (div_done)
  );

  // Neighbour tile in the move direction, pinned to the current tile at the maze border
  always_comb begin
    adj_row = cur_row_q;
    adj_col = cur_col_q;
    case (dir_q)
      DIR_UP:    if (cur_row_q != 5'd0) adj_row = cur_row_q - 5'd1;
      DIR_DOWN:  if (({1'b0, cur_row_q} + 6'd1) < {1'b0, num_rows}) adj_row = cur_row_q + 5'd1;
      DIR_LEFT:  if (cur_col_q != 5'd0) adj_col = cur_col_q - 5'd1;
      DIR_RIGHT: if (({1'b0, cur_col_q} + 6'd1) < {1'b0, num_cols}) adj_col = cur_col_q + 5'd1;
      default: ;
    endcase
  end

  // A wall only blocks when the player is already within the margin of that edge.
  // The pixel-range guards keep pos_y out of the info bar and pos_x from wrapping.
  always_comb begin
    blocked = 1'b1;
    case (dir_q)
      DIR_UP: blocked = ((walls_cur_q[WALL_TOP] | walls_adj_q[WALL_BOT]) && (div_y_rem <= margin_w))
                        || (pos_y_q < 11'(INFOBAR_H + STEP));
      DIR_DOWN: blocked = (walls_cur_q[WALL_BOT] | walls_adj_q[WALL_TOP])
                          && ((div_y_rem + 11'(BLK)) >= sat_sub({1'b0, tile_h}, margin_w));
      DIR_LEFT: blocked = ((walls_cur_q[WALL_LEFT] | walls_adj_q[WALL_RIGHT]) && (div_x_rem <= margin_w))
                          || (pos_x_q < 11'(STEP));
      DIR_RIGHT: blocked = (walls_cur_q[WALL_RIGHT] | walls_adj_q[WALL_LEFT])
                           && ((div_x_rem + 11'(BLK)) >= sat_sub({1'b0, tile_w}, margin_w));
      default: blocked = 1'b1;
    endcase
  end

  // Main FSM. Each lookup drops wall_req on its ack; the adjacent request is
  // raised one cycle later so the ROM always sees a fresh request edge.
  // level_change/respawn override everything at the end of the block.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    walls_cur_d = walls_cur_q;
    walls_adj_d = walls_adj_q;
    wall_req_d  = wall_req_q;
    wall_row_d  = wall_row_q;
    wall_col_d  = wall_col_q;
    move_done_d = 1'b0;
    div_start   = 1'b0;
    div_abort   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick && dir_one_hot(btn_dir)) begin
          dir_d     = btn_dir;
          div_start = 1'b1;
          state_d   = ST_DIV;
        end
      end
      ST_DIV: begin
        if ((tile_w == 10'd0) || (tile_h == 10'd0)) begin
          div_abort = 1'b1;
          state_d   = ST_IDLE;
        end else if (div_done) begin
          cur_row_d  = div_y_quot;
          cur_col_d  = div_x_quot;
          wall_row_d = div_y_quot;
          wall_col_d = div_x_quot;
          wall_req_d = 1'b1;
          state_d    = ST_LOOK_CUR;
        end
      end
      ST_LOOK_CUR: begin
        if (wall_req_q && wall_ack) begin
          walls_cur_d = walls_in;
          wall_req_d  = 1'b0;
          wall_row_d  = adj_row;
          wall_col_d  = adj_col;
          state_d     = ST_LOOK_ADJ;
        end
      end
      ST_LOOK_ADJ: begin
        if (!wall_req_q) begin
          wall_req_d = 1'b1;
        end else if (wall_ack) begin
          walls_adj_d = walls_in;
          wall_req_d  = 1'b0;
          state_d     = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        if (!blocked) begin
          move_done_d = 1'b1;
          case (dir_q)
            DIR_UP:    pos_y_d = pos_y_q - 11'(STEP);
            DIR_DOWN:  pos_y_d = pos_y_q + 11'(STEP);
            DIR_LEFT:  pos_x_d = pos_x_q - 11'(STEP);
            DIR_RIGHT: pos_x_d = pos_x_q + 11'(STEP);
            default: ;
          endcase
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef WALL_ACK_TIMEOUT_EN
    tmo_d = 4'd0;
    if (((state_q == ST_LOOK_CUR) || (state_q == ST_LOOK_ADJ)) && wall_req_q && !wall_ack) begin
      if (tmo_q == 4'(ACK_TIMEOUT - 1)) begin
        wall_req_d = 1'b0;
        state_d    = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 4'd1;
      end
    end
`endif

    if (level_change || respawn) begin
      pos_x_d     = 11'(START_X);
      pos_y_d     = 11'(START_Y);
      wall_req_d  = 1'b0;
      move_done_d = 1'b0;
      div_start   = 1'b0;
      div_abort   = 1'b1;
      state_d     = ST_IDLE;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dir_q       <= 4'd0;
      pos_x_q     <= 11'(START_X);
      pos_y_q     <= 11'(START_Y);
      cur_row_q   <= 5'd0;
      cur_col_q   <= 5'd0;
      walls_cur_q <= 4'd0;
      walls_adj_q <= 4'd0;
      wall_req_q  <= 1'b0;
      wall_row_q  <= 5'd0;
      wall_col_q  <= 5'd0;
      move_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      cur_row_q   <= cur_row_d;
      cur_col_q   <= cur_col_d;
      walls_cur_q <= walls_cur_d;
      walls_adj_q <= walls_adj_d;
      wall_req_q  <= wall_req_d;
      wall_row_q  <= wall_row_d;
      wall_col_q  <= wall_col_d;
      move_done_q <= move_done_d;
    end
  end

`ifdef WALL_ACK_TIMEOUT_EN
  // Ack-timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= 4'd0;
    else     tmo_q <= tmo_d;
  end
`endif

  assign wall_req  = wall_req_q;
  assign wall_row  = wall_row_q;
  assign wall_col  = wall_col_q;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign cur_row   = cur_row_q;
  assign cur_col   = cur_col_q;
  assign busy      = (state_q != ST_IDLE);
  assign move_done = move_done_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// tb_player_move_ctrl
// Directed bench for player_move_ctrl with a level-ROM responder model.
// Tile geometry 80x60, margin 4, 8x8 level. Expected positions are worked
// out by hand from the spawn point (394,141) and STEP=2.
module tb_player_move_ctrl;

  localparam logic [3:0] UP    = 4'b0001;
  localparam logic [3:0] LEFT  = 4'b0010;
  localparam logic [3:0] RIGHT = 4'b0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, respawn, level_change;
  logic [3:0]  btn_dir;
  logic [9:0]  tile_w, tile_h, wall_margin;
  logic [4:0]  num_rows, num_cols;
  logic        wall_req, wall_ack;
  logic [4:0]  wall_row, wall_col;
  logic [3:0]  walls_in;
  logic [10:0] pos_x, pos_y;
  logic [4:0]  cur_row, cur_col;
  logic        busy, move_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Responder model state
  bit         ack_en = 1'b1;
  int         ack_limit = 2;
  int         lk_idx = 0;
  logic [3:0] rsp_cur = 4'd0;
  logic [3:0] rsp_adj = 4'd0;
  logic [4:0] adj_row_seen = 5'd0;
  logic [4:0] adj_col_seen = 5'd0;

  // Per-move observations
  int done_cnt;
  bit req_seen;
  bit wait_ok;
  int cyc;

  player_move_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .btn_dir      (btn_dir),
    .respawn      (respawn),
    .level_change (level_change),
    .tile_w       (tile_w),
    .tile_h       (tile_h),
    .wall_margin  (wall_margin),
    .num_rows     (num_rows),
    .num_cols     (num_cols),
    .wall_req     (wall_req),
    .wall_row     (wall_row),
    .wall_col     (wall_col),
    .wall_ack     (wall_ack),
    .walls_in     (walls_in),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .cur_row      (cur_row),
    .cur_col      (cur_col),
    .busy         (busy),
    .move_done    (move_done)
  );

  always #5 clk = ~clk;

  // Level ROM stand-in: the first lookup of a move returns rsp_cur, the second rsp_adj
  always @(negedge clk) begin
    if (wall_ack) begin
      wall_ack = 1'b0;
    end else if (ack_en && wall_req && (lk_idx < ack_limit)) begin
      wall_ack = 1'b1;
      walls_in = (lk_idx == 0) ? rsp_cur : rsp_adj;
      if (lk_idx == 1) begin
        adj_row_seen = wall_row;
        adj_col_seen = wall_col;
      end
      lk_idx++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One tick with the given direction and ROM contents, then wait for the FSM to settle
  task automatic applyStimulus(input logic [3:0] dir, input logic [3:0] wc, input logic [3:0] wa);
    @(negedge clk);
    rsp_cur  = wc;
    rsp_adj  = wa;
    lk_idx   = 0;
    btn_dir  = dir;
    tick     = 1'b1;
    done_cnt = 0;
    req_seen = 1'b0;
    wait_ok  = 1'b0;
    @(negedge clk);
    tick = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (move_done) done_cnt++;
      if (wall_req) req_seen = 1'b1;
      if (!busy) begin
        wait_ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("move_finished", 32'(wait_ok), 32'd1);
    @(negedge clk);
    if (move_done) done_cnt++;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; respawn = 1'b0; level_change = 1'b0; btn_dir = 4'd0;
    tile_w = 10'd80; tile_h = 10'd60; wall_margin = 10'd4; num_rows = 5'd8; num_cols = 5'd8;
    wall_ack = 1'b0; walls_in = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    checkOutput("rst_pos_x", 32'(pos_x), 32'd394);
    checkOutput("rst_pos_y", 32'(pos_y), 32'd141);
    checkOutput("rst_cur_row", 32'(cur_row), 32'd0);
    checkOutput("rst_cur_col", 32'(cur_col), 32'd0);
    checkOutput("rst_wall_req", 32'(wall_req), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_move_done", 32'(move_done), 32'd0);

    // First up move: 394/80 -> col 4, 41/60 -> row 0; adjacent clamps to (0,4)
    applyStimulus(UP, 4'b0000, 4'b0000);
    checkOutput("up1_cur_col", 32'(cur_col), 32'd4);
    checkOutput("up1_cur_row", 32'(cur_row), 32'd0);
    checkOutput("up1_pos_y", 32'(pos_y), 32'd139);
    checkOutput("up1_done", 32'(done_cnt), 32'd1);
    checkOutput("up1_adj_row", 32'(adj_row_seen), 32'd0);
    checkOutput("up1_adj_col", 32'(adj_col_seen), 32'd4);

    // Walk up to y=103 (y_rem 3, inside the margin)
    for (int k = 0; k < 18; k++) applyStimulus(UP, 4'b0000, 4'b0000);
    checkOutput("walk_pos_y", 32'(pos_y), 32'd103);

    applyStimulus(UP, 4'b1000, 4'b0000);
    checkOutput("top_wall_pos_y", 32'(pos_y), 32'd103);
    checkOutput("top_wall_done", 32'(done_cnt), 32'd0);

    applyStimulus(UP, 4'b0000, 4'b0000);
    checkOutput("no_wall_pos_y", 32'(pos_y), 32'd101);
    checkOutput("no_wall_done", 32'(done_cnt), 32'd1);

    // 101-2 would enter the info bar
    applyStimulus(UP, 4'b0000, 4'b0000);
    checkOutput("infobar_pos_y", 32'(pos_y), 32'd101);
    checkOutput("infobar_done", 32'(done_cnt), 32'd0);

    // Left to x=384 (x_rem 64), then right against the neighbour's left wall
    for (int k = 0; k < 5; k++) applyStimulus(LEFT, 4'b0000, 4'b0000);
    checkOutput("walk_pos_x", 32'(pos_x), 32'd384);

    applyStimulus(RIGHT, 4'b0000, 4'b0010);
    checkOutput("right_free_pos_x", 32'(pos_x), 32'd386);
    checkOutput("right_free_done", 32'(done_cnt), 32'd1);
    checkOutput("right_adj_col", 32'(adj_col_seen), 32'd5);

    applyStimulus(RIGHT, 4'b0000, 4'b0010);
    checkOutput("right_block_pos_x", 32'(pos_x), 32'd386);
    checkOutput("right_block_done", 32'(done_cnt), 32'd0);

    // Two buttons at once: tick ignored
    applyStimulus(4'b0011, 4'b0000, 4'b0000);
    checkOutput("bad_dir_req", 32'(req_seen), 32'd0);
    checkOutput("bad_dir_done", 32'(done_cnt), 32'd0);

    // Zero tile width: no lookup, no move
    tile_w = 10'd0;
    applyStimulus(UP, 4'b0000, 4'b0000);
    checkOutput("zero_div_req", 32'(req_seen), 32'd0);
    checkOutput("zero_div_pos_y", 32'(pos_y), 32'd101);
    tile_w = 10'd80;

    // level_change while the adjacent lookup is outstanding
    @(negedge clk);
    ack_limit = 1; lk_idx = 0; btn_dir = UP; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if ((lk_idx == 1) && wall_req) begin
        wait_ok = 1'b1;
        break;
      end
    end
    checkOutput("lc_reach_adj", 32'(wait_ok), 32'd1);
    level_change = 1'b1; tick = 1'b1;
    @(negedge clk);
    level_change = 1'b0; tick = 1'b0;
    checkOutput("lc_wall_req", 32'(wall_req), 32'd0);
    checkOutput("lc_pos_x", 32'(pos_x), 32'd394);
    checkOutput("lc_pos_y", 32'(pos_y), 32'd141);
    checkOutput("lc_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("lc_tick_ignored", 32'(busy), 32'd0);
    ack_limit = 2;

    // A second tick while busy is dropped, not queued
    @(negedge clk);
    lk_idx = 0; rsp_cur = 4'd0; rsp_adj = 4'd0; btn_dir = UP; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    done_cnt = 0; req_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (move_done) done_cnt++;
      if (busy) req_seen = 1'b1;
      @(negedge clk);
      if (!busy && !move_done && i > 30) req_seen = 1'b0;
    end
    checkOutput("drop_done", 32'(done_cnt), 32'd1);
    checkOutput("drop_pos_y", 32'(pos_y), 32'd139);
    checkOutput("drop_idle", 32'(busy), 32'd0);

    // Respawn
    @(negedge clk); respawn = 1'b1;
    @(negedge clk); respawn = 1'b0;
    checkOutput("respawn_pos_y", 32'(pos_y), 32'd141);

    // ROM never answers
    @(negedge clk);
    ack_en = 1'b0; lk_idx = 0; btn_dir = UP; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
`ifdef WALL_ACK_TIMEOUT_EN
    wait_ok = 1'b0; cyc = 0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) begin
        wait_ok = 1'b1;
        break;
      end
      cyc++;
      @(negedge clk);
    end
    checkOutput("tmo_aborted", 32'(wait_ok), 32'd1);
    checkOutput("tmo_not_early", 32'(cyc >= 15), 32'd1);
    checkOutput("tmo_pos_y", 32'(pos_y), 32'd141);
    checkOutput("tmo_wall_req", 32'(wall_req), 32'd0);
    ack_en = 1'b1;
`else
    repeat (40) @(negedge clk);
    checkOutput("noack_busy", 32'(busy), 32'd1);
    checkOutput("noack_req", 32'(wall_req), 32'd1);
    ack_en = 1'b1;
    wait_ok = 1'b0; done_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (move_done) done_cnt++;
      if (!busy) begin
        wait_ok = 1'b1;
        break;
      end
    end
    checkOutput("noack_resume", 32'(wait_ok), 32'd1);
    checkOutput("noack_done", 32'(done_cnt), 32'd1);
    checkOutput("noack_pos_y", 32'(pos_y), 32'd139);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
